// File: rtl/fc_decision_if.sv
// Score stream into the decision stage and the smoothed decision coming back out.
// The master side produces scores; the slave side is the decision block.
interface fc_decision_if #(
  parameter int DW = 16
);
  logic                 score_valid;
  logic signed [DW-1:0] score_data;
  logic                 score_last;
  logic                 valid_out;
  logic                 data_out;
  logic                 frame_err;
  logic [3:0]           open_votes;

  modport master (
    output score_valid, score_data, score_last,
    input  valid_out, data_out, frame_err, open_votes
  );

  modport slave (
    input  score_valid, score_data, score_last,
    output valid_out, data_out, frame_err, open_votes
  );
endinterface

// File: rtl/fc_decision.sv
// Per-frame argmax over serialised class scores, followed by a majority vote
// over the last VOTE_N frames, producing one open/closed pulse per good frame.
module fc_decision #(
  parameter int DW         = 16,
  parameter int NUM_CLASS  = 2,
  parameter int OPEN_CLASS = 1,
  parameter int VOTE_N     = 5
) (
  input  logic        clk,
  input  logic        rst,
  fc_decision_if.slave bus
);
  localparam int            IW        = $clog2(NUM_CLASS);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CLASS - 1);
  localparam logic [IW-1:0] OPEN_IDX  = IW'(OPEN_CLASS);
  localparam logic [3:0]    VOTE_INIT = 4'(VOTE_N);
  localparam logic [3:0]    HALF      = 4'(VOTE_N / 2);

  typedef enum logic {ACCUM, DROP} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic signed [DW-1:0] best_score_q, best_score_d;
  logic [IW-1:0]        best_idx_q, best_idx_d;
  logic                 vote_fire, vote_bit, err_d;
  logic [VOTE_N-1:0]    hist_q, hist_d;
  logic [3:0]           open_votes_q, open_votes_d;
  logic                 fire_q, valid_q, data_q, err_q;
  logic                 oldest;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    vote_fire    = 1'b0;
    vote_bit     = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      ACCUM: begin
        if (bus.score_valid) begin
          // Strictly-greater replacement keeps the lower index on ties.
          if (idx_q == '0 || bus.score_data > best_score_q) begin
            best_score_d = bus.score_data;
            best_idx_d   = idx_q;
          end
          if (bus.score_last) begin
            idx_d = '0;
            if (idx_q == LAST_IDX) begin
              vote_fire = 1'b1;
              vote_bit  = (best_idx_d == OPEN_IDX);
            end else begin
              err_d = 1'b1;
            end
          end else if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            err_d   = 1'b1;
            state_d = DROP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DROP: begin
        if (bus.score_valid && bus.score_last) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  assign oldest = hist_q[VOTE_N-1];

  generate
    if (VOTE_N == 1) begin : g_hist_single
      assign hist_d = vote_bit;
    end else begin : g_hist_shift
      assign hist_d = {hist_q[VOTE_N-2:0], vote_bit};
    end
  endgenerate

  // Running count: a bit shifted out was already counted, so this never underflows.
  assign open_votes_d = open_votes_q + {3'b000, vote_bit} - {3'b000, oldest};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      idx_q        <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
      hist_q       <= '1;
      open_votes_q <= VOTE_INIT;
      fire_q       <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      best_score_q <= best_score_d;
      best_idx_q   <= best_idx_d;
      if (vote_fire) begin
        hist_q       <= hist_d;
        open_votes_q <= open_votes_d;
      end
      fire_q  <= vote_fire;
      err_q   <= err_d;
      valid_q <= fire_q;
      if (fire_q) begin
        data_q <= (open_votes_q > HALF);
      end
    end
  end

  assign bus.valid_out  = valid_q;
  assign bus.data_out   = data_q;
  assign bus.frame_err  = err_q;
  assign bus.open_votes = open_votes_q;
endmodule
